mem_bus_responder: RTL and testbench

//  Memory-side responder for the processor memory bus (ADDR/READ/WRITE/DATA).

---
 rtl/mem_bus_responder.sv | 212 +++++++++++++++++++++
 tb/tb_mem_bus_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: serves word reads/writes to a local SRAM window
// after a programmable wait latency, signals completion with a one-cycle READY
// pulse, flags out-of-window accesses and conflicting strobes with ERR, and
// counts committed in-window writes.
module mem_bus_responder #(
  parameter int unsigned       ADDR_W    = 26,
  parameter int unsigned       DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h00048000),
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_data_in,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_ready,
  output logic              o_err,
  output logic [15:0]       o_wr_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WCNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_REARM = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Captured request, held for the whole access
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_wr;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] r_data_out;
  logic              r_ready;
  logic              r_err;
  logic [WCNT_W-1:0] r_wr_count;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_rd;
  logic              w_wr;
  logic              w_one;
  logic              w_both;
  logic              w_any;
  logic              w_cap;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_acc_wr;
  logic [ADDR_W-1:0] w_off;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic              w_enter_done;
  logic              w_commit;
  logic              w_load_rd;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_data_out_nxt;
  logic              w_ready_nxt;
  logic              w_err_nxt;
  logic [WCNT_W-1:0] w_wr_count_nxt;

  // Strobe decode; anything other than a clean 1 counts as inactive
  always_comb begin
    w_rd   = (i_read === 1'b1);
    w_wr   = (i_write === 1'b1);
    w_one  = w_rd ^ w_wr;
    w_both = w_rd & w_wr;
    w_any  = w_rd | w_wr;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a dropped strobe in WAIT aborts even on the last count
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_both) begin
          w_state_nxt = S_REARM;
        end else if (w_one) begin
          w_state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_any) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_REARM;
      end
      S_REARM: begin
        if (!w_any) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Access view: live bus in IDLE (single-cycle latency commits on capture), captured copy afterwards
  always_comb begin
    w_cap        = (r_state == S_IDLE) && w_one;
    w_acc_addr   = (r_state == S_IDLE) ? i_addr    : r_addr;
    w_acc_data   = (r_state == S_IDLE) ? i_data_in : r_data;
    w_acc_wr     = (r_state == S_IDLE) ? w_wr      : r_wr;
    w_off        = w_acc_addr - BASE_ADDR;
    w_hit        = (w_acc_addr >= BASE_ADDR) && (w_off < ADDR_W'(DEPTH));
    w_idx        = w_off[IDX_W-1:0];
    w_enter_done = (w_state_nxt == S_DONE);
    w_commit     = w_enter_done && w_acc_wr && w_hit;
    w_load_rd    = w_enter_done && !w_acc_wr;
  end

  // Output and datapath next values
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_data_out_nxt = r_data_out;
    w_ready_nxt    = 1'b0;
    w_err_nxt      = 1'b0;
    w_wr_count_nxt = r_wr_count;

    if (w_cap) begin
      w_cnt_nxt = CNT_LOAD;
    end else if (r_state == S_WAIT) begin
      w_cnt_nxt = r_cnt - CNT_W'(1);
    end

    if (w_load_rd) begin
      w_data_out_nxt = w_hit ? r_mem[w_idx] : '0;
    end

    if (w_commit) begin
      w_wr_count_nxt = r_wr_count + WCNT_W'(1);
    end

    if (r_state == S_DONE) begin
      w_ready_nxt = 1'b1;
      w_err_nxt   = !w_hit;
    end else if ((r_state == S_IDLE) && w_both) begin
      w_err_nxt = 1'b1;
    end
  end

  // Request capture and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_wr   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_cap) begin
        r_addr <= i_addr;
        r_data <= i_data_in;
        r_wr   <= w_wr;
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Registered bus outputs and write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_data_out <= w_data_out_nxt;
      r_ready    <= w_ready_nxt;
      r_err      <= w_err_nxt;
      r_wr_count <= w_wr_count_nxt;
    end
  end

  // SRAM array; contents survive reset
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= w_acc_data;
    end
  end

  assign o_data_out = r_data_out;
  assign o_ready    = r_ready;
  assign o_err      = r_err;
  assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (latency 2, 4, 1) on a shared
// clock/reset, directed scenarios plus randomized traffic against a
// transaction-level memory model.
module tb_mem_bus_responder;

  localparam int NDUT  = 3;
  localparam int DEPTH = 64;
  localparam logic [25:0] BASE = 26'h0048000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [25:0] addr [NDUT];
  logic        rd   [NDUT];
  logic        wr   [NDUT];
  logic [31:0] din  [NDUT];
  logic [31:0] dout [NDUT];
  logic        rdy  [NDUT];
  logic        err  [NDUT];
  logic [15:0] wcnt [NDUT];

  logic [31:0] m_mem  [NDUT][DEPTH];
  bit          m_vld  [NDUT][DEPTH];
  logic [15:0] m_wcnt [NDUT];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(.ADDR_W(26), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .i_addr(addr[0]), .i_read(rd[0]), .i_write(wr[0]), .i_data_in(din[0]),
    .o_data_out(dout[0]), .o_ready(rdy[0]), .o_err(err[0]), .o_wr_count(wcnt[0]));

  mem_bus_responder #(.ADDR_W(26), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .i_addr(addr[1]), .i_read(rd[1]), .i_write(wr[1]), .i_data_in(din[1]),
    .o_data_out(dout[1]), .o_ready(rdy[1]), .o_err(err[1]), .o_wr_count(wcnt[1]));

  mem_bus_responder #(.ADDR_W(26), .DATA_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .i_addr(addr[2]), .i_read(rd[2]), .i_write(wr[2]), .i_data_in(din[2]),
    .o_data_out(dout[2]), .o_ready(rdy[2]), .o_err(err[2]), .o_wr_count(wcnt[2]));

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit in_win(input logic [25:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Complete a single read or write and check handshake, latency, result
  task automatic access(input int d, input bit op_wr, input logic [25:0] a,
                        input logic [31:0] data, input string tag);
    int j;
    int idx;
    bit seen;
    bit hit;
    bit dknown;
    logic [31:0] exp_d;
    @(negedge clk);
    addr[d] = a; din[d] = data; rd[d] = !op_wr; wr[d] = op_wr;
    hit    = in_win(a);
    idx    = hit ? int'(longint'(a) - longint'(BASE)) : 0;
    dknown = 1'b1;
    exp_d  = 32'h0;
    if (op_wr && hit) begin
      m_mem[d][idx] = data;
      m_vld[d][idx] = 1'b1;
      m_wcnt[d]     = m_wcnt[d] + 16'd1;
    end
    if (!op_wr && hit) begin
      exp_d  = m_mem[d][idx];
      dknown = m_vld[d][idx];
    end
    seen = 1'b0;
    j    = 0;
    while (!seen && j < 20) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) seen = 1'b1;
      else j++;
    end
    chk({tag, " ready"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(j), 32'(lat_of(d)));
    chk({tag, " err"}, 32'(err[d]), 32'(!hit));
    if (!op_wr && dknown) chk({tag, " data"}, dout[d], exp_d);
    chk({tag, " wr_count"}, 32'(wcnt[d]), 32'(m_wcnt[d]));
    rd[d] = 1'b0; wr[d] = 1'b0;
    @(negedge clk);
    chk({tag, " ready pulse"}, 32'(rdy[d]), 32'd0);
  endtask

  // Strobe held for h capture/wait edges then dropped before completion
  task automatic abort_access(input int d, input bit op_wr, input logic [25:0] a,
                              input logic [31:0] data, input int h, input string tag);
    bit any;
    @(negedge clk);
    addr[d] = a; din[d] = data; rd[d] = !op_wr; wr[d] = op_wr;
    any = 1'b0;
    repeat (h) begin
      @(negedge clk);
      if (rdy[d] === 1'b1 || err[d] === 1'b1) any = 1'b1;
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    repeat (lat_of(d) + 3) begin
      @(negedge clk);
      if (rdy[d] === 1'b1 || err[d] === 1'b1) any = 1'b1;
    end
    chk({tag, " no response"}, 32'(any), 32'd0);
    chk({tag, " wr_count"}, 32'(wcnt[d]), 32'(m_wcnt[d]));
  endtask

  // Both strobes: ERR alone, then held in rearm while any strobe remains
  task automatic both_access(input int d, input logic [25:0] a, input logic [31:0] data,
                             input string tag);
    bit any;
    @(negedge clk);
    addr[d] = a; din[d] = data; rd[d] = 1'b1; wr[d] = 1'b1;
    @(negedge clk);
    chk({tag, " err"}, 32'(err[d]), 32'd1);
    chk({tag, " ready"}, 32'(rdy[d]), 32'd0);
    wr[d] = 1'b0;
    any = 1'b0;
    repeat (lat_of(d) + 3) begin
      @(negedge clk);
      if (rdy[d] === 1'b1 || err[d] === 1'b1) any = 1'b1;
    end
    chk({tag, " rearm hold"}, 32'(any), 32'd0);
    rd[d] = 1'b0;
    @(negedge clk);
    chk({tag, " wr_count"}, 32'(wcnt[d]), 32'(m_wcnt[d]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] a;
    logic [31:0] v;
    int d;
    int lat;

    for (int i = 0; i < NDUT; i++) begin
      addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; din[i] = '0; m_wcnt[i] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        m_vld[i][k] = 1'b0;
        m_mem[i][k] = '0;
      end
    end

    // Reset and idle outputs
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("reset ready[%0d]", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("reset err[%0d]", i), 32'(err[i]), 32'd0);
      chk($sformatf("reset data[%0d]", i), dout[i], 32'd0);
      chk($sformatf("reset wr_count[%0d]", i), 32'(wcnt[i]), 32'd0);
    end

    // Basic write then read back
    access(0, 1'b1, 26'h0048003, 32'hDEADBEEF, "wr48003");
    chk("wr48003 count one", 32'(wcnt[0]), 32'd1);
    access(0, 1'b0, 26'h0048003, 32'h0, "rd48003");
    chk("rd48003 value", dout[0], 32'hDEADBEEF);

    // Window boundaries
    access(0, 1'b0, 26'h0047FFF, 32'h0, "rd47fff");
    access(0, 1'b0, 26'h0048040, 32'h0, "rd48040");
    access(0, 1'b1, 26'h0048040, 32'h12345678, "wr48040");
    access(0, 1'b1, 26'h004803F, 32'hCAFEF00D, "wr4803f");
    access(0, 1'b0, 26'h004803F, 32'h0, "rd4803f");
    access(0, 1'b1, 26'h0048000, 32'h0BADC0DE, "wr48000");
    access(0, 1'b0, 26'h0048000, 32'h0, "rd48000");

    // Conflicting strobes leave memory untouched
    both_access(0, 26'h0048003, 32'h11111111, "both");
    access(0, 1'b0, 26'h0048003, 32'h0, "rd after both");
    chk("both no store", dout[0], 32'hDEADBEEF);

    // Abort in WAIT on the latency-4 instance
    access(1, 1'b1, 26'h0048005, 32'hA5A5A5A5, "l4 wr5");
    abort_access(1, 1'b1, 26'h0048005, 32'h5A5A5A5A, 1, "l4 abort");
    access(1, 1'b0, 26'h0048005, 32'h0, "l4 rd5");
    chk("l4 abort no store", dout[1], 32'hA5A5A5A5);

    // Randomized mixed traffic
    for (int it = 0; it < 150; it++) begin
      d   = $urandom_range(0, NDUT - 1);
      lat = lat_of(d);
      case ($urandom_range(0, 5))
        0:       a = BASE - 26'($urandom_range(1, 3));
        1:       a = BASE + 26'(DEPTH) + 26'($urandom_range(0, 3));
        2:       a = BASE;
        3:       a = BASE + 26'(DEPTH - 1);
        default: a = BASE + 26'($urandom_range(0, DEPTH - 1));
      endcase
      v = $urandom;
      case ($urandom_range(0, 9))
        0:       both_access(d, a, v, "rnd both");
        1: begin
          if (lat > 1) abort_access(d, $urandom_range(0, 1) == 1, a, v, $urandom_range(1, lat - 1), "rnd abort");
          else access(d, 1'b1, a, v, "rnd wr");
        end
        2, 3, 4: access(d, 1'b1, a, v, "rnd wr");
        default: access(d, 1'b0, a, v, "rnd rd");
      endcase
    end

    // Reset in the middle of a WAIT on the latency-4 instance
    access(1, 1'b1, 26'h004800A, 32'h600DF00D, "l4 wr10");
    @(negedge clk);
    addr[1] = 26'h004800A; din[1] = 32'hBAADBAAD; wr[1] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      chk($sformatf("midreset ready[%0d]", i), 32'(rdy[i]), 32'd0);
      chk($sformatf("midreset err[%0d]", i), 32'(err[i]), 32'd0);
      chk($sformatf("midreset data[%0d]", i), dout[i], 32'd0);
      chk($sformatf("midreset wr_count[%0d]", i), 32'(wcnt[i]), 32'd0);
      m_wcnt[i] = '0;
    end
    wr[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      bit any;
      any = 1'b0;
      repeat (8) begin
        @(negedge clk);
        if (rdy[1] === 1'b1) any = 1'b1;
      end
      chk("midreset no ready", 32'(any), 32'd0);
    end
    access(1, 1'b0, 26'h004800A, 32'h0, "l4 rd10");
    chk("midreset write lost", dout[1], 32'h600DF00D);

    // Full-window sweeps on latency-2 and latency-1 instances
    for (int k = 0; k < DEPTH; k++) begin
      access(0, 1'b1, BASE + 26'(k), 32'(k), "sweep l2 wr");
      access(2, 1'b1, BASE + 26'(k), 32'(k), "sweep l1 wr");
    end
    chk("sweep l2 count", 32'(wcnt[0]), 32'd64);
    chk("sweep l1 count", 32'(wcnt[2]), 32'd64);
    for (int k = 0; k < DEPTH; k++) begin
      access(0, 1'b0, BASE + 26'(k), 32'h0, "sweep l2 rd");
      chk("sweep l2 index", dout[0], 32'(k));
      access(2, 1'b0, BASE + 26'(k), 32'h0, "sweep l1 rd");
      chk("sweep l1 index", dout[2], 32'(k));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
